// File: rtl/chaos_op_sequencer.sv
// chaos_op_sequencer
// Sequences (op, a, b) requests onto the key-configured chaotic logic datapath.
// Each op maps to one of NUM_VAR equivalent 12-bit gate keys held in a programmable
// table. A 16-bit LFSR picks the variant per request, falling back to the
// lowest-index valid variant. The datapath result is captured and returned over
// a valid/ready response port.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   cfg_we/op/var/key   key-table write (sets entry valid)
//   cfg_clr             clear entry valid bit (ignored when cfg_we=1)
//   rekey_en            1: LFSR picks variant; 0: variant 0 preferred
//   req_*               request channel (valid/ready, op, operands)
//   rsp_*               response channel (valid/ready, result, variant, error)
//   chaos_a/b/key       registered datapath drive
//   chaos_y             datapath result, combinational from chaos_*
module chaos_op_sequencer #(
    parameter int unsigned NUM_OPS   = 4,
    parameter int unsigned NUM_VAR   = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int unsigned OP_W     = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1,
    localparam int unsigned VAR_W    = (NUM_VAR > 1) ? $clog2(NUM_VAR) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [OP_W-1:0]  cfg_op,
    input  logic [VAR_W-1:0] cfg_var,
    input  logic [11:0]      cfg_key,
    input  logic             cfg_clr,
    input  logic             rekey_en,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP_W-1:0]  req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_y,
    output logic [VAR_W-1:0] rsp_var,
    output logic             rsp_err,
    output logic [31:0]      chaos_a,
    output logic [31:0]      chaos_b,
    output logic [11:0]      chaos_key,
    input  logic [31:0]      chaos_y
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e             state_q, state_d;
    logic               up_q;  // low for the cycle after reset so req_ready stays 0
    logic [15:0]        lfsr_q, lfsr_d, lfsr_next;
    logic [31:0]        chaos_a_q, chaos_a_d;
    logic [31:0]        chaos_b_q, chaos_b_d;
    logic [11:0]        chaos_key_q, chaos_key_d;
    logic [31:0]        rsp_y_q, rsp_y_d;
    logic [VAR_W-1:0]   rsp_var_q, rsp_var_d;
    logic               rsp_err_q, rsp_err_d;

    logic [11:0]        key_tbl_q [NUM_OPS][NUM_VAR];
    logic [NUM_VAR-1:0] key_vld_q [NUM_OPS];

    logic [NUM_VAR-1:0] op_vld;
    logic [VAR_W-1:0]   v0, sel_var;
    logic               sel_ok;

    // Fibonacci x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Key table: contents are unreset; only the valid bits are cleared by rst.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            key_tbl_q[cfg_op][cfg_var] <= cfg_key;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_OPS); i++) begin
                key_vld_q[i] <= '0;
            end
        end else if (cfg_we) begin
            key_vld_q[cfg_op][cfg_var] <= 1'b1;
        end else if (cfg_clr) begin
            key_vld_q[cfg_op][cfg_var] <= 1'b0;
        end
    end

    // Variant pick: preferred v0 if valid, else lowest-index valid variant.
    always_comb begin
        op_vld  = key_vld_q[req_op];
        v0      = rekey_en ? lfsr_q[VAR_W-1:0] : '0;
        sel_ok  = 1'b0;
        sel_var = '0;
        if (int'(v0) < int'(NUM_VAR) && op_vld[v0]) begin
            sel_ok  = 1'b1;
            sel_var = v0;
        end else begin
            // Descending scan so the lowest valid index wins
            for (int i = int'(NUM_VAR) - 1; i >= 0; i--) begin
                if (op_vld[i]) begin
                    sel_ok  = 1'b1;
                    sel_var = VAR_W'(i);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        chaos_a_d   = chaos_a_q;
        chaos_b_d   = chaos_b_q;
        chaos_key_d = chaos_key_q;
        rsp_y_d     = rsp_y_q;
        rsp_var_d   = rsp_var_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    lfsr_d = lfsr_next;
                    if (sel_ok) begin
                        chaos_a_d   = req_a;
                        chaos_b_d   = req_b;
                        chaos_key_d = key_tbl_q[req_op][sel_var];
                        rsp_var_d   = sel_var;
                        state_d     = StExec;
                    end else begin
                        // No usable key: skip the datapath, chaos_* stay cleared
                        rsp_err_d = 1'b1;
                        rsp_y_d   = '0;
                        rsp_var_d = '0;
                        state_d   = StResp;
                    end
                end
            end
            StExec: begin
                rsp_y_d   = chaos_y;
                rsp_err_d = 1'b0;
                state_d   = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    // Scrub datapath drive so the key is not left exposed while idle
                    chaos_a_d   = '0;
                    chaos_b_d   = '0;
                    chaos_key_d = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            up_q        <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            chaos_a_q   <= '0;
            chaos_b_q   <= '0;
            chaos_key_q <= '0;
            rsp_y_q     <= '0;
            rsp_var_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            up_q        <= 1'b1;
            lfsr_q      <= lfsr_d;
            chaos_a_q   <= chaos_a_d;
            chaos_b_q   <= chaos_b_d;
            chaos_key_q <= chaos_key_d;
            rsp_y_q     <= rsp_y_d;
            rsp_var_q   <= rsp_var_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == StIdle) && up_q;
    assign rsp_valid = (state_q == StResp);
    assign rsp_y     = rsp_y_q;
    assign rsp_var   = rsp_var_q;
    assign rsp_err   = rsp_err_q;
    assign chaos_a   = chaos_a_q;
    assign chaos_b   = chaos_b_q;
    assign chaos_key = chaos_key_q;

endmodule

// File: tb/tb_chaos_op_sequencer.sv
// Self-checking bench for chaos_op_sequencer. Datapath stub: y = a ^ b ^ key.
module tb_chaos_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we, cfg_clr, rekey_en;
    logic [1:0]  cfg_op, cfg_var;
    logic [11:0] cfg_key;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_y;
    logic [1:0]  rsp_var;
    logic [31:0] chaos_a, chaos_b, chaos_y;
    logic [11:0] chaos_key;

    always #5 clk = ~clk;

    assign chaos_y = chaos_a ^ chaos_b ^ {20'b0, chaos_key};

    chaos_op_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_op    (cfg_op),
        .cfg_var   (cfg_var),
        .cfg_key   (cfg_key),
        .cfg_clr   (cfg_clr),
        .rekey_en  (rekey_en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_var   (rsp_var),
        .rsp_err   (rsp_err),
        .chaos_a   (chaos_a),
        .chaos_b   (chaos_b),
        .chaos_key (chaos_key),
        .chaos_y   (chaos_y)
    );

    int errors = 0;
    int checks = 0;

    // Bench-side reference state
    logic [15:0] lfsr_m;
    logic [11:0] key_m [4][4];
    logic [3:0]  vld_m [4];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic [1:0]  vsel;
        logic        err;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge. Issues one request, waits for the response and checks it.
    task automatic run_req(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_y,
                           input logic [1:0] exp_var, input logic exp_err);
        int n;
        int lat;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk({name, " accept"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lfsr_m = lfsr_step(lfsr_m);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 32'(lat), exp_err ? 32'd1 : 32'd2);
        chk({name, " rsp_y"}, rsp_y, exp_y);
        chk({name, " rsp_var"}, 32'(rsp_var), 32'(exp_var));
        chk({name, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    endtask

    // Expected response from the reference table and LFSR state.
    task automatic run_model_req(input string name, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        logic [1:0] v0;
        int         v;
        v0 = rekey_en ? lfsr_m[1:0] : 2'd0;
        v  = -1;
        if (vld_m[op][v0]) begin
            v = int'(v0);
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (vld_m[op][i]) v = i;
            end
        end
        if (v < 0) run_req(name, op, a, b, 32'd0, 2'd0, 1'b1);
        else       run_req(name, op, a, b, a ^ b ^ {20'b0, key_m[op][v]}, 2'(v), 1'b0);
    endtask

    task automatic cfg_write(input logic [1:0] op, input logic [1:0] v, input logic [11:0] k);
        cfg_we  = 1'b1;
        cfg_op  = op;
        cfg_var = v;
        cfg_key = k;
        @(negedge clk);
        cfg_we = 1'b0;
        key_m[op][v] = k;
        vld_m[op][v] = 1'b1;
    endtask

    task automatic cfg_clear(input logic [1:0] op, input logic [1:0] v);
        cfg_clr = 1'b1;
        cfg_op  = op;
        cfg_var = v;
        @(negedge clk);
        cfg_clr = 1'b0;
        vld_m[op][v] = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, " idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] held_y;

        // Hand-computed vectors, rekey_en=0, table: (1,0)=0A5, (3,2)=3C0
        vecs[0] = '{2'd1, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00FAA, 2'd0, 1'b0};
        vecs[1] = '{2'd2, 32'h12345678, 32'h00000000, 32'h00000000, 2'd0, 1'b1};
        vecs[2] = '{2'd3, 32'h00000000, 32'h00000000, 32'h000003C0, 2'd2, 1'b0};
        vecs[3] = '{2'd3, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFC3F, 2'd2, 1'b0};
        vecs[4] = '{2'd1, 32'h12345678, 32'h87654321, 32'h955115FC, 2'd0, 1'b0};
        vecs[5] = '{2'd0, 32'hDEADBEEF, 32'h01234567, 32'h00000000, 2'd0, 1'b1};

        rst = 1'b1;
        cfg_we = 1'b0; cfg_clr = 1'b0; cfg_op = '0; cfg_var = '0; cfg_key = '0;
        rekey_en = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b1;
        lfsr_m = 16'hACE1;
        for (int i = 0; i < 4; i++) begin
            vld_m[i] = 4'b0;
            for (int j = 0; j < 4; j++) key_m[i][j] = 12'h0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_y", rsp_y, 32'd0);
        chk("reset chaos_key", 32'(chaos_key), 32'd0);
        chk("reset chaos_a", chaos_a, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset req_ready", 32'(req_ready), 32'd1);

        // Empty table -> error response at N+1
        run_req("empty op2", 2'd2, 32'hCAFEF00D, 32'h1, 32'd0, 2'd0, 1'b1);
        chk("empty chaos_key", 32'(chaos_key), 32'd0);

        // Table-driven vectors
        cfg_write(2'd1, 2'd0, 12'h0A5);
        cfg_write(2'd3, 2'd2, 12'h3C0);
        for (int i = 0; i < 6; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].y, vecs[i].vsel, vecs[i].err);
        end

        // LFSR-driven variant selection on op0
        wait_idle("rekey");
        cfg_write(2'd0, 2'd0, 12'h101);
        cfg_write(2'd0, 2'd1, 12'h2A2);
        cfg_write(2'd0, 2'd2, 12'h3C3);
        cfg_write(2'd0, 2'd3, 12'h4E4);
        rekey_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rekey%0d model var", i), 32'(vld_m[0]), 32'hF);
            run_model_req($sformatf("rekey%0d", i), 2'd0, 32'h01010101 * i, 32'h5A5A0000);
            chk($sformatf("rekey%0d lfsr var", i), 32'(rsp_var), 32'(lfsr_step_inv(lfsr_m)));
        end
        wait_idle("only v2");
        cfg_clear(2'd0, 2'd0);
        cfg_clear(2'd0, 2'd1);
        cfg_clear(2'd0, 2'd3);
        for (int i = 0; i < 4; i++) begin
            run_model_req($sformatf("onlyv2_%0d", i), 2'd0, 32'h11111111 << i, 32'h0);
            chk($sformatf("onlyv2_%0d var", i), 32'(rsp_var), 32'd2);
        end
        rekey_en = 1'b0;

        // Response backpressure
        wait_idle("stall");
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_op = 2'd3; req_a = 32'h0; req_b = 32'h0;
        @(negedge clk);
        lfsr_m = lfsr_step(lfsr_m);
        req_op = 2'd1;  // second request held pending
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("stall latency", 32'(lat), 32'd2);
        held_y = rsp_y;
        chk("stall rsp_y", held_y, 32'h000003C0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("stall%0d rsp_y", i), rsp_y, 32'h000003C0);
            chk($sformatf("stall%0d req_ready", i), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("after hs rsp_valid", 32'(rsp_valid), 32'd0);
        chk("after hs chaos_key", 32'(chaos_key), 32'd0);
        chk("after hs chaos_a", chaos_a, 32'd0);
        chk("after hs req_ready", 32'(req_ready), 32'd1);

        // Table write colliding with accept: old key used, next request sees new key
        wait_idle("collide");
        req_valid = 1'b1; req_op = 2'd1; req_a = 32'h0; req_b = 32'h0;
        cfg_we = 1'b1; cfg_op = 2'd1; cfg_var = 2'd0; cfg_key = 12'h5A5;
        @(negedge clk);
        req_valid = 1'b0;
        cfg_we = 1'b0;
        lfsr_m = lfsr_step(lfsr_m);
        key_m[1][0] = 12'h5A5;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("collide latency", 32'(lat), 32'd2);
        chk("collide old key", rsp_y, 32'h000000A5);
        run_req("collide new key", 2'd1, 32'h0, 32'h0, 32'h000005A5, 2'd0, 1'b0);

        // Reset during EXEC
        wait_idle("rst exec");
        req_valid = 1'b1; req_op = 2'd1; req_a = 32'h00000001; req_b = 32'h00000002;
        @(negedge clk);
        req_valid = 1'b0;
        chk("exec rsp_valid", 32'(rsp_valid), 32'd0);
        chk("exec chaos_key", 32'(chaos_key), 32'h5A5);
        rst = 1'b1;
        @(negedge clk);
        chk("rst exec rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst exec chaos_a", chaos_a, 32'd0);
        chk("rst exec chaos_b", chaos_b, 32'd0);
        chk("rst exec chaos_key", 32'(chaos_key), 32'd0);
        chk("rst exec req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        lfsr_m = 16'hACE1;
        for (int i = 0; i < 4; i++) vld_m[i] = 4'b0;
        @(negedge clk);
        chk("rst exec ready after", 32'(req_ready), 32'd1);
        run_model_req("rst table empty", 2'd1, 32'h1, 32'h2);
        chk("rst table empty err", 32'(rsp_err), 32'd1);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Recovers the pre-advance LFSR low bits: the bit shifted out of [1:0] is
    // state bit 1 before the step, i.e. bit 2 now; old bit 0 is now bit 1.
    function automatic logic [1:0] lfsr_step_inv(input logic [15:0] s);
        return s[2:1];
    endfunction

endmodule
